// File: rtl/wgt_bram.sv
// wgt_bram: NBANK independent dual-port weight banks, each DEPTH words of WIDTH bits.
// A fill engine can write one init word into every bank. It runs one address per cycle.
//
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   d_r/d_w                 per-bank write data; bank b occupies bits [WIDTH*b +: WIDTH]
//   addr_r/addr_w           per-bank address; bank b occupies bits [AW*b +: AW]
//   ce_r/ce_w, we_r/we_w    per-bank access enable / write enable
//   q_r/q_w                 per-bank registered read data
//   i_clear, i_init_wgt     start a fill with {4{i_init_wgt}}
//   o_busy, o_clear_done    fill in progress / one-cycle completion pulse
//   o_addr_err              sticky: an enabled access used an address >= DEPTH
//
// Build option: define WGT_BRAM_FWD_EN to make same-address read/write on opposite ports
// write-first (read port returns the new data). Without the macro the bank is read-first.
module wgt_bram #(
    parameter int unsigned NBANK = 6,
    parameter int unsigned DEPTH = 432,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NBANK*WIDTH-1:0] d_r,
    input  logic [NBANK*WIDTH-1:0] d_w,
    input  logic [NBANK*AW-1:0]    addr_r,
    input  logic [NBANK*AW-1:0]    addr_w,
    input  logic [NBANK-1:0]       ce_r,
    input  logic [NBANK-1:0]       ce_w,
    input  logic [NBANK-1:0]       we_r,
    input  logic [NBANK-1:0]       we_w,
    output logic [NBANK*WIDTH-1:0] q_r,
    output logic [NBANK*WIDTH-1:0] q_w,
    input  logic                   i_clear,
    input  logic [15:0]            i_init_wgt,
    output logic                   o_busy,
    output logic                   o_clear_done,
    output logic                   o_addr_err
);

    localparam logic [AW-1:0] MaxAddr = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e                       state_q;
    logic [AW-1:0]                fill_cnt_q;
    logic [15:0]                  init_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;
    logic [NBANK-1:0][WIDTH-1:0]  q_r_q;
    logic [NBANK-1:0][WIDTH-1:0]  q_w_q;

    // Not reset: contents survive reset_n.
    logic [WIDTH-1:0]             mem [NBANK][DEPTH];

    logic [AW-1:0]                a_r [NBANK];
    logic [AW-1:0]                a_w [NBANK];
    logic [NBANK-1:0]             oob_r, oob_w;
    logic [NBANK-1:0]             rd_r_en, rd_w_en;
    logic [NBANK-1:0]             wr_r_en, wr_w_en;
    logic                         clr;
    logic                         err_hit;
    logic [WIDTH-1:0]             fill_word;

    assign clr       = (state_q == StClear);
    assign fill_word = {(WIDTH / 16){init_q}};

    always_comb begin
        err_hit = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            a_r[b]     = addr_r[b*AW +: AW];
            a_w[b]     = addr_w[b*AW +: AW];
            oob_r[b]   = a_r[b] > MaxAddr;
            oob_w[b]   = a_w[b] > MaxAddr;
            rd_r_en[b] = ce_r[b] & ~we_r[b];
            rd_w_en[b] = ce_w[b] & ~we_w[b];
            wr_r_en[b] = ce_r[b] & we_r[b] & ~oob_r[b] & ~clr;
            wr_w_en[b] = ce_w[b] & we_w[b] & ~oob_w[b] & ~clr;
            err_hit    = err_hit | (ce_r[b] & oob_r[b]) | (ce_w[b] & oob_w[b]);
        end
    end

    // Port w is written last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (clr) begin
                mem[b][fill_cnt_q] <= fill_word;
            end else begin
                if (wr_r_en[b]) mem[b][a_r[b]] <= d_r[b*WIDTH +: WIDTH];
                if (wr_w_en[b]) mem[b][a_w[b]] <= d_w[b*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r_q <= '0;
            q_w_q <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (rd_r_en[b]) begin
                    if (clr || oob_r[b]) begin
                        q_r_q[b] <= '0;
`ifdef WGT_BRAM_FWD_EN
                    end else if (wr_w_en[b] && (a_w[b] == a_r[b])) begin
                        q_r_q[b] <= d_w[b*WIDTH +: WIDTH];
`endif
                    end else begin
                        q_r_q[b] <= mem[b][a_r[b]];
                    end
                end
                if (rd_w_en[b]) begin
                    if (clr || oob_w[b]) begin
                        q_w_q[b] <= '0;
`ifdef WGT_BRAM_FWD_EN
                    end else if (wr_r_en[b] && (a_r[b] == a_w[b])) begin
                        q_w_q[b] <= d_r[b*WIDTH +: WIDTH];
`endif
                    end else begin
                        q_w_q[b] <= mem[b][a_w[b]];
                    end
                end
            end
        end
    end

    // Fill FSM; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fill_cnt_q <= '0;
            init_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_clear) begin
                        state_q    <= StClear;
                        busy_q     <= 1'b1;
                        fill_cnt_q <= '0;
                        init_q     <= i_init_wgt;
                    end
                end
                StClear: begin
                    if (fill_cnt_q == MaxAddr) begin
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        fill_cnt_q <= '0;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + AW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Address errors are not recorded while a fill owns the banks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (!clr && err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign q_r          = q_r_q;
    assign q_w          = q_w_q;
    assign o_busy       = busy_q;
    assign o_clear_done = done_q;
    assign o_addr_err   = err_q;

endmodule

// File: tb/tb_wgt_bram.sv
module tb_wgt_bram;

    localparam int NB = 6;
    localparam int DP = 432;
    localparam logic [63:0] FILL1 = 64'h0100010001000100;
    localparam logic [63:0] FILL2 = 64'h00AA00AA00AA00AA;
`ifdef WGT_BRAM_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [383:0] d_r, d_w, q_r, q_w;
    logic [53:0]  addr_r, addr_w;
    logic [5:0]   ce_r, ce_w, we_r, we_w;
    logic         i_clear;
    logic [15:0]  i_init_wgt;
    logic         o_busy, o_clear_done, o_addr_err;

    wgt_bram dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .d_r          (d_r),
        .d_w          (d_w),
        .addr_r       (addr_r),
        .addr_w       (addr_w),
        .ce_r         (ce_r),
        .ce_w         (ce_w),
        .we_r         (we_r),
        .we_w         (we_w),
        .q_r          (q_r),
        .q_w          (q_w),
        .i_clear      (i_clear),
        .i_init_wgt   (i_init_wgt),
        .o_busy       (o_busy),
        .o_clear_done (o_clear_done),
        .o_addr_err   (o_addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays of words plus the expected output registers.
    logic [63:0]  mdl [NB][DP];
    logic [383:0] exp_q_r, exp_q_w;
    logic         exp_err;

    task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ce_r = '0; ce_w = '0; we_r = '0; we_w = '0;
        addr_r = '0; addr_w = '0; d_r = '0; d_w = '0;
        i_clear = 1'b0;
    endtask

    // One clock of port traffic; model predicts outputs, then everything is compared.
    task automatic apply(input logic [5:0] cer, input logic [5:0] wer, input logic [5:0] cew,
                         input logic [5:0] wew, input logic [53:0] ar, input logic [53:0] aw,
                         input logic [383:0] dr, input logic [383:0] dw);
        int ra, wa;
        ce_r = cer; we_r = wer; ce_w = cew; we_w = wew;
        addr_r = ar; addr_w = aw; d_r = dr; d_w = dw;
        for (int b = 0; b < NB; b++) begin
            ra = int'(ar[b*9 +: 9]);
            wa = int'(aw[b*9 +: 9]);
            if ((cer[b] && ra >= DP) || (cew[b] && wa >= DP)) exp_err = 1'b1;
            if (cer[b] && !wer[b]) begin
                if (ra >= DP) exp_q_r[b*64 +: 64] = '0;
                else if (Fwd && cew[b] && wew[b] && wa == ra) exp_q_r[b*64 +: 64] = dw[b*64 +: 64];
                else exp_q_r[b*64 +: 64] = mdl[b][ra];
            end
            if (cew[b] && !wew[b]) begin
                if (wa >= DP) exp_q_w[b*64 +: 64] = '0;
                else if (Fwd && cer[b] && wer[b] && wa == ra) exp_q_w[b*64 +: 64] = dr[b*64 +: 64];
                else exp_q_w[b*64 +: 64] = mdl[b][wa];
            end
            if (cer[b] && wer[b] && ra < DP) mdl[b][ra] = dr[b*64 +: 64];
            if (cew[b] && wew[b] && wa < DP) mdl[b][wa] = dw[b*64 +: 64];
        end
        @(posedge clk); #1;
        check("q_r", q_r, exp_q_r);
        check("q_w", q_w, exp_q_w);
        check("addr_err", {383'b0, o_addr_err}, {383'b0, exp_err});
        idle_inputs();
    endtask

    // Single-bank read on both ports.
    task automatic rd(input int b, input int ar, input int aw);
        apply(6'(1) << b, 6'd0, 6'(1) << b, 6'd0, 54'(ar) << (b*9), 54'(aw) << (b*9), '0, '0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        exp_q_r = '0; exp_q_w = '0; exp_err = 1'b0;
        check("rst_q_r", q_r, '0);
        check("rst_q_w", q_w, '0);
        check("rst_flags", {381'b0, o_busy, o_clear_done, o_addr_err}, '0);
        #3 reset_n = 1'b1;
    endtask

    typedef struct {
        int bank;
        bit cer, wer; int ar; logic [63:0] dr;
        bit cew, wew; int aw; logic [63:0] dw;
        bit chk_r; logic [63:0] er;
        bit chk_w; logic [63:0] ew;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int busy_n, done_n;
        vec_t v;
        logic [5:0]   rc, rw, wc, ww;
        logic [53:0]  ra, wa;
        logic [383:0] rdat, wdat;
        int x;

        idle_inputs();
        i_init_wgt = 16'h0000;
        exp_q_r = '0; exp_q_w = '0; exp_err = 1'b0;
        reset_n = 1'b0;
        #2;
        check("reset_q_r", q_r, '0);
        check("reset_q_w", q_w, '0);
        check("reset_flags", {381'b0, o_busy, o_clear_done, o_addr_err}, '0);
        #10 reset_n = 1'b1;

        // Fill; i_clear is held high through CLEAR and DONE and must be ignored there.
        i_init_wgt = 16'h0100;
        i_clear = 1'b1;
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 440; c++) begin
            @(posedge clk); #1;
            if (o_busy) busy_n++;
            if (o_clear_done) done_n++;
            i_clear = o_busy | o_clear_done;
        end
        i_clear = 1'b0;
        check("fill_busy_cycles", 384'(busy_n), 384'(432));
        check("fill_done_pulses", 384'(done_n), 384'(1));
        check("fill_idle", {382'b0, o_busy, o_clear_done}, '0);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++) mdl[b][a] = FILL1;

        // bank, cer,wer,ar,dr, cew,wew,aw,dw, chk_r,er, chk_w,ew
        tbl[0]  = '{0, 0, 0, 0, 0, 1, 1, 5, 64'h2, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 5, 0, 1, 1, 5, 64'h1, 1, (Fwd ? 64'h1 : 64'h2), 0, 0};
        tbl[2]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 64'h1, 0, 0};
        tbl[3]  = '{3, 0, 0, 0, 0, 1, 1, 431, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0};
        tbl[4]  = '{3, 1, 0, 431, 0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 0};
        tbl[5]  = '{1, 1, 1, 10, 64'hAAAA, 1, 1, 10, 64'hBBBB, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 1, 64'hBBBB};
        tbl[7]  = '{1, 1, 0, 10, 0, 0, 0, 0, 0, 1, 64'hBBBB, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 1, 10, 64'hCC, 0, 0, 1, 64'hBBBB};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hBBBB};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 1, 64'hCC};
        tbl[11] = '{5, 1, 0, 431, 0, 0, 0, 0, 0, 1, FILL1, 0, 0};
        tbl[12] = '{2, 0, 0, 0, 0, 1, 0, 431, 0, 0, 0, 1, FILL1};
        tbl[13] = '{4, 1, 0, 0, 0, 0, 0, 0, 0, 1, FILL1, 0, 0};

        for (int i = 0; i < 14; i++) begin
            v = tbl[i];
            apply(6'(v.cer) << v.bank, 6'(v.wer) << v.bank, 6'(v.cew) << v.bank,
                  6'(v.wew) << v.bank, 54'(v.ar) << (v.bank*9), 54'(v.aw) << (v.bank*9),
                  384'(v.dr) << (v.bank*64), 384'(v.dw) << (v.bank*64));
            if (v.chk_r) check($sformatf("vec%0d_q_r", i), 384'(q_r[v.bank*64 +: 64]), 384'(v.er));
            if (v.chk_w) check($sformatf("vec%0d_q_w", i), 384'(q_w[v.bank*64 +: 64]), 384'(v.ew));
        end

        // Random traffic on a small address set so collisions are frequent.
        for (int n = 0; n < 300; n++) begin
            rc = 6'($urandom); rw = 6'($urandom); wc = 6'($urandom); ww = 6'($urandom);
            for (int b = 0; b < NB; b++) begin
                x = int'($urandom_range(0, 7));
                ra[b*9 +: 9] = 9'((x < 4) ? x : 424 + x);
                x = int'($urandom_range(0, 7));
                wa[b*9 +: 9] = 9'((x < 4) ? x : 424 + x);
                rdat[b*64 +: 64] = {$urandom, $urandom};
                wdat[b*64 +: 64] = {$urandom, $urandom};
            end
            apply(rc, rw, wc, ww, ra, wa, rdat, wdat);
        end

        // Out-of-range access: zero read data and a sticky error flag.
        check("err_clean", {383'b0, o_addr_err}, '0);
        rd(2, 0, 0);
        apply(6'b000100, 6'd0, 6'd0, 6'd0, 54'(432) << 18, '0, '0, '0);
        check("oob_q_r", 384'(q_r[191:128]), '0);
        check("oob_err", {383'b0, o_addr_err}, 384'(1));
        apply(6'd0, 6'd0, 6'b000001, 6'b000001, '0, 54'(500), '0, 384'(64'h5555));
        for (int i = 0; i < 3; i++) apply('0, '0, '0, '0, '0, '0, '0, '0);
        check("err_sticky", {383'b0, o_addr_err}, 384'(1));
        pulse_reset();
        rd(3, 431, 5);

        // Accesses during a fill, then reset part-way through it.
        apply(6'd0, 6'd0, 6'b000001, 6'b000001, '0, 54'(200), '0, 384'(64'h1234));
        i_init_wgt = 16'h00AA;
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
        check("fill2_busy", {383'b0, o_busy}, 384'(1));
        ce_r = 6'b000011; addr_r = (54'(3) << 9) | 54'(432);
        ce_w = 6'b100000; we_w = 6'b100000; addr_w = 54'(300) << 45;
        d_w = 384'(64'hFFFF) << 320;
        @(posedge clk); #1;
        idle_inputs();
        exp_q_r[127:0] = '0;
        check("clear_rd_zero", q_r, exp_q_r);
        check("clear_no_err", {383'b0, o_addr_err}, '0);
        for (int c = 0; c < 99; c++) @(posedge clk);
        #1;
        pulse_reset();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 100; a++) mdl[b][a] = FILL2;
        rd(0, 99, 100);
        check("abort_addr99", 384'(q_r[63:0]), 384'(FILL2));
        rd(0, 200, 0);
        check("abort_addr200", 384'(q_r[63:0]), 384'(64'h1234));
        check("abort_addr0", 384'(q_w[63:0]), 384'(FILL2));
        rd(5, 300, 99);
        check("clear_wr_dropped", 384'(q_r[383:320]), 384'(FILL1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
